mdu_sequencer: RTL
==================

Name: mdu_sequencer

Overview:
- Multiply/divide unit with its own sequencer for the five-stage MIPS pipeline.
- Accepts md/mt/mf operations from the E stage and owns the HI/LO registers.
- Models the fixed multi-cycle latency of mult/div (busy counter).
- Generates the D-stage stall for any md/mt/mf instruction that must wait.

Parameters:
- MULT_LAT, 5, cycles busy is held for mult/multu (>=1).
- DIV_LAT, 10, cycles busy is held for div/divu (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset; all state clears while low.
- start  input  1  E-stage md instruction valid this cycle.
- op  input  3  operation code: 0 mult, 1 multu, 2 div, 3 divu, 4 mtlo, 5 mthi, 6 mflo, 7 mfhi.
- rs_val  input  32  forwarded rs operand (dividend / multiplicand / mt source).
- rt_val  input  32  forwarded rt operand (divisor / multiplier).
- mt_en  input  1  E-stage mtlo/mthi valid this cycle.
- cancel  input  1  pipeline flush; aborts the in-flight operation.
- d_md_use  input  1  D-stage instruction is md/mt/mf.
- busy  output  1  operation in flight.
- stall  output  1  D-stage stall request.
- hi  output  32  HI register.
- lo  output  32  LO register.
- mf_data  output  32  mf read value.

Behaviour:
- Reset: hi=0, lo=0, busy=0, state IDLE, counter=0, internal result registers=0.
- States:
  - IDLE: start && !cancel && op in {0..3} → latch the op result into hi_nx/lo_nx; counter=MULT_LAT (op 0/1) or DIV_LAT (op 2/3); go to RUN.
  - RUN: counter decrements every cycle. On the edge where counter==1, commit hi_nx/lo_nx to hi/lo and go to IDLE.
- busy = (state==RUN). For a start sampled at edge T, busy is high for exactly LAT cycles. New hi/lo are visible from edge T+LAT.
- Arithmetic:
  - mult: signed 32x32 → 64; HI=[63:32], LO=[31:0]. multu: the unsigned form.
  - div: LO=quotient, HI=remainder, truncation toward zero; remainder takes the sign of the dividend. divu: the unsigned form.
  - Divisor 0: hi/lo stay unchanged at commit; full latency still elapses.
- mt: in IDLE, mt_en with op 4 writes lo=rs_val at the next edge; op 5 writes hi=rs_val. mt_en while busy is ignored (prevented by stall).
- mf_data = (op==7) ? hi : lo. Combinational, current register value, no bypass of hi_nx/lo_nx.
- stall = d_md_use && (start || busy). Combinational; covers the cycle start is in E.
- start while busy: ignored, no restart.
- start && mt_en in the same cycle: start wins (illegal encoding; mt dropped).
- cancel:
  - cancel in RUN → next edge: IDLE, busy=0, hi/lo untouched, counter=0.
  - cancel with start in the same cycle: start dropped.
  - cancel with mt_en: mt dropped.
- Reset asserted mid-operation: immediate clear, no commit.

Optional Feature:
- Macro MDU_DIV0_TRAP_EN.
- Defined:
  - Adds output port div0 (1 bit, reset 0).
  - div/divu with rt_val==0 does not enter RUN. div0 pulses high for exactly the cycle after start; busy stays 0; hi/lo unchanged.
- Undefined: no div0 port; divide-by-zero takes the full DIV_LAT latency as above.

Test Plan:
- Reset, then mult rs=0xFFFFFFFF rt=0x00000002 at edge 0 → busy high cycles 1–5, hi=0xFFFFFFFF lo=0xFFFFFFFE at edge 5.
- multu with the same operands → hi=0x00000001 lo=0xFFFFFFFE after 5 cycles.
- div rs=0xFFFFFFF9 (-7) rt=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF after 10 cycles. divu rs=7 rt=2 → lo=3, hi=1.
- mflo in D while div busy → stall=1 each cycle until busy drops; mf_data equals the new lo on the first unstalled cycle. d_md_use alongside start → stall=1 that same cycle.
- mthi rs=0x12345678 in IDLE → hi=0x12345678 next edge; mtlo rs=0xCAFEBABE → lo updated, hi unchanged.
- div started, cancel at cycle 4 → busy=0 next edge, hi/lo keep their pre-div values. Reset pulse low mid-mult → hi=lo=0, busy=0 immediately. With MDU_DIV0_TRAP_EN: div rt=0 → div0=1 for one cycle, busy never set.

Source files
------------

// File: rtl/mdu_sequencer.sv
// -----------------------------------------------------------------------------
// mdu_sequencer
//
// Multiply/divide unit and sequencer for the five-stage MIPS pipeline. It owns
// the HI/LO registers and accepts mult/multu/div/divu plus mthi/mtlo from the
// E stage. The arithmetic result is computed when the operation starts and is
// parked in hi_nx/lo_nx. A down-counter holds busy for the fixed latency, and
// the result is committed to HI/LO when the counter expires. The unit also
// raises the D-stage stall for any md/mt/mf instruction that would race an
// operation in flight.
//
// Parameters:
//   MULT_LAT  cycles busy is held for mult/multu (>=1)
//   DIV_LAT   cycles busy is held for div/divu (>=1)
//
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   asynchronous active-low reset
//   start     in   E-stage md instruction valid
//   op[2:0]   in   0 mult, 1 multu, 2 div, 3 divu, 4 mtlo, 5 mthi, 6 mflo, 7 mfhi
//   rs_val    in   rs operand (dividend / multiplicand / mt source)
//   rt_val    in   rt operand (divisor / multiplier)
//   mt_en     in   E-stage mtlo/mthi valid
//   cancel    in   pipeline flush, aborts the operation in flight
//   d_md_use  in   D-stage instruction is md/mt/mf
//   busy      out  operation in flight
//   stall     out  D-stage stall request
//   hi, lo    out  HI/LO registers
//   div0      out  (only with MDU_DIV0_TRAP_EN) one-cycle divide-by-zero pulse
//   mf_data   out  mfhi/mflo read value
//
// Build option:
//   MDU_DIV0_TRAP_EN  When this is defined, a divide with rt_val==0 never enters
//                     RUN. Instead the unit pulses div0 for one cycle.
// -----------------------------------------------------------------------------
module mdu_sequencer #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        mt_en,
    input  logic        cancel,
    input  logic        d_md_use,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo,
`ifdef MDU_DIV0_TRAP_EN
    output logic        div0,
`endif
    output logic [31:0] mf_data
);

    localparam int LAT_MAX = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(LAT_MAX + 1);

    typedef logic [CNT_W-1:0] cnt_t;
    localparam cnt_t MULT_CNT = cnt_t'(MULT_LAT);
    localparam cnt_t DIV_CNT  = cnt_t'(DIV_LAT);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state, state_next;
    cnt_t        cnt, cnt_next;
    logic [31:0] hi_next, lo_next;
    logic [31:0] hi_nx, lo_nx, hi_nx_next, lo_nx_next;
    logic [63:0] md_res;
    logic        is_md, is_div, is_signed, div_by_zero;
`ifdef MDU_DIV0_TRAP_EN
    logic        div0_next;
`endif

    // Full 64-bit product. When the operands are sign-extended to 64 bits, the
    // modulo-2^64 product is the exact signed product.
    function automatic logic [63:0] mul_full(input logic [31:0] a,
                                             input logic [31:0] b,
                                             input logic        sgn);
        logic signed [63:0] sa, sb, sp;
        sa = sgn ? {{32{a[31]}}, a} : {32'h0, a};
        sb = sgn ? {{32{b[31]}}, b} : {32'h0, b};
        sp = sa * sb;
        return sp;
    endfunction

    // Returns {remainder, quotient}. The signed form divides the magnitudes,
    // then restores the signs: the quotient truncates toward zero, and the
    // remainder follows the dividend. Working on magnitudes keeps
    // 0x80000000 / -1 well defined (quotient 0x80000000, remainder 0).
    function automatic logic [63:0] div_full(input logic [31:0] a,
                                             input logic [31:0] b,
                                             input logic        sgn);
        logic        neg_q, neg_r;
        logic [31:0] ma, mb, q, r;
        neg_r = sgn & a[31];
        neg_q = sgn & (a[31] ^ b[31]);
        ma    = neg_r ? (~a + 32'd1) : a;
        mb    = (sgn & b[31]) ? (~b + 32'd1) : b;
        if (mb == 32'h0) begin
            q = 32'h0;
            r = 32'h0;
        end else begin
            q = ma / mb;
            r = ma % mb;
        end
        q = neg_q ? (~q + 32'd1) : q;
        r = neg_r ? (~r + 32'd1) : r;
        return {r, q};
    endfunction

    assign is_md       = ~op[2];
    assign is_div      = op[1];
    assign is_signed   = ~op[0];
    assign div_by_zero = is_div && (rt_val == 32'h0);

    // Result of the operation presented this cycle. A zero divisor recirculates
    // the current HI/LO, so the commit leaves them unchanged.
    always_comb begin
        md_res = {hi, lo};
        if (is_div) begin
            if (!div_by_zero)
                md_res = div_full(rs_val, rt_val, is_signed);
        end else begin
            md_res = mul_full(rs_val, rt_val, is_signed);
        end
    end

    // Next-state and register-update logic.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        hi_next    = hi;
        lo_next    = lo;
        hi_nx_next = hi_nx;
        lo_nx_next = lo_nx;
`ifdef MDU_DIV0_TRAP_EN
        div0_next  = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                // start takes priority over mt_en. cancel drops both.
                if (start && !cancel) begin
                    if (is_md) begin
`ifdef MDU_DIV0_TRAP_EN
                        if (div_by_zero) begin
                            div0_next = 1'b1;
                        end else begin
                            state_next = RUN;
                            cnt_next   = is_div ? DIV_CNT : MULT_CNT;
                            hi_nx_next = md_res[63:32];
                            lo_nx_next = md_res[31:0];
                        end
`else
                        state_next = RUN;
                        cnt_next   = is_div ? DIV_CNT : MULT_CNT;
                        hi_nx_next = md_res[63:32];
                        lo_nx_next = md_res[31:0];
`endif
                    end
                end else if (mt_en && !cancel) begin
                    if (op == 3'd4)
                        lo_next = rs_val;
                    else if (op == 3'd5)
                        hi_next = rs_val;
                end
            end
            RUN: begin
                // start and mt_en are ignored here. A flush abandons the result.
                if (cancel) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt == cnt_t'(1)) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    hi_next    = hi_nx;
                    lo_next    = lo_nx;
                end else begin
                    cnt_next = cnt - cnt_t'(1);
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // State / HI-LO register boundary.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            hi    <= 32'h0;
            lo    <= 32'h0;
            hi_nx <= 32'h0;
            lo_nx <= 32'h0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            hi    <= hi_next;
            lo    <= lo_next;
            hi_nx <= hi_nx_next;
            lo_nx <= lo_nx_next;
        end
    end

`ifdef MDU_DIV0_TRAP_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            div0 <= 1'b0;
        else
            div0 <= div0_next;
    end
`endif

    assign busy    = (state == RUN);
    // The stall also covers the cycle in which start is still in E.
    assign stall   = d_md_use && (start || busy);
    assign mf_data = (op == 3'd7) ? hi : lo;

endmodule
